// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: IDLE/PLAY/PAUSE/FINISH sequencing, game tick divider,
// remaining-time countdown, saturating BCD score and the Row1 display cells.
module game_flow_ctrl #(
  parameter int TICK_DIV     = 100000000,
  parameter int GAME_TICKS   = 15,
  parameter int SCORE_DIGITS = 4,
  parameter int COLS         = 8,
  parameter int CELL_W       = 5,
  parameter int DARK_IDX     = 31
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      pause_btn,
  input  logic                      hit_valid,
  input  logic [3:0]                hit_points,
  output logic [1:0]                state,
  output logic                      playing,
  output logic                      game_tick,
  output logic [6:0]                time_left,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic [COLS*CELL_W-1:0]    ScoreRow,
  output logic                      finished,
  output logic                      finish_pulse
);

  localparam int CNT_W   = $clog2(TICK_DIV);
  localparam int SCORE_W = 4 * SCORE_DIGITS;
  localparam int ROW_W   = COLS * CELL_W;

  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(TICK_DIV - 1);
  localparam logic [6:0]         TL_LOAD   = 7'(GAME_TICKS);
  localparam logic [SCORE_W-1:0] ALL_NINES = {SCORE_DIGITS{4'h9}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_PAUSE  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t             cur_st, nxt_st;
  logic               en_q, pause_q;
  logic               en_rise, pause_rise;
  logic               reload;
  logic               count_en, cnt_at_max, last_tick;
  logic [CNT_W-1:0]   cnt;
  logic [SCORE_W-1:0] score_q, score_add, digit_acc;
  logic [4:0]         digit_sum;
  logic [3:0]         carry;

  // Builds one display row: time-left digits in cells 0/1, score digits in the
  // rightmost cells (MS digit leftmost), everything else blank. Idle hides score.
  function automatic logic [ROW_W-1:0] compose_row(input logic               idle,
                                                   input logic [6:0]         tl,
                                                   input logic [SCORE_W-1:0] sc);
    logic [ROW_W-1:0] row;
    logic [6:0]       tens, units;
    row   = {COLS{CELL_W'(DARK_IDX)}};
    tens  = tl / 7'd10;
    units = tl % 7'd10;
    row[ROW_W-CELL_W   +: CELL_W] = CELL_W'(tens);
    row[ROW_W-2*CELL_W +: CELL_W] = CELL_W'(units);
    if (!idle) begin
      for (int d = 0; d < SCORE_DIGITS; d++) begin
        row[d*CELL_W +: CELL_W] = CELL_W'(sc[4*d +: 4]);
      end
    end
    return row;
  endfunction

  assign en_rise    = en & ~en_q;
  assign pause_rise = pause_btn & ~pause_q;

  // Restart and pause pre-empt counting: the cycle they act on neither advances
  // the divider nor scores, so a tick due on that cycle fires once play resumes.
  assign count_en   = (cur_st == ST_PLAY) & ~en_rise & ~pause_rise;
  assign cnt_at_max = (cnt == CNT_MAX);
  assign game_tick  = count_en & cnt_at_max;
  assign last_tick  = game_tick & (time_left == 7'd1);

  assign state     = cur_st;
  assign playing   = (cur_st == ST_PLAY);
  assign finished  = (cur_st == ST_FINISH);
  assign score_bcd = score_q;

  // Input edge-detect history.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst) begin
      // Reset high so a button already held through reset does not register.
      en_q    <= 1'b1;
      pause_q <= 1'b1;
    end else begin
      en_q    <= en;
      pause_q <= pause_btn;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur_st <= ST_IDLE;
    else      cur_st <= nxt_st;
  end

  // Next-state and reload decode; en_rise beats pause_rise beats tick.
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latches).
    nxt_st = cur_st;
    reload = 1'b0;
    unique case (cur_st)
      ST_IDLE: begin
        if (en_rise) begin
          nxt_st = ST_PLAY;
          reload = 1'b1;
        end
      end
      ST_PLAY: begin
        if (en_rise) begin
          nxt_st = ST_PLAY;
          reload = 1'b1;
        end else if (pause_rise) begin
          nxt_st = ST_PAUSE;
        end else if (last_tick) begin
          nxt_st = ST_FINISH;
        end
      end
      ST_PAUSE: begin
        if (en_rise) begin
          nxt_st = ST_PLAY;
          reload = 1'b1;
        end else if (pause_rise) begin
          nxt_st = ST_PLAY;
        end
      end
      ST_FINISH: begin
        if (en_rise) begin
          nxt_st = ST_PLAY;
          reload = 1'b1;
        end
      end
      default: nxt_st = ST_IDLE;
    endcase
  end

  // BCD add of the clamped hit value with digit-to-digit carry; saturate on overflow.
  always_comb begin
    // NOTE: blocking assignments here let carry ripple through the loop in order.
    digit_acc = '0;
    digit_sum = '0;
    carry     = (hit_points > 4'd9) ? 4'd9 : hit_points;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      digit_sum = 5'(score_q[4*i +: 4]) + 5'(carry);
      if (digit_sum > 5'd9) begin
        digit_acc[4*i +: 4] = 4'(digit_sum - 5'd10);
        carry               = 4'd1;
      end else begin
        digit_acc[4*i +: 4] = digit_sum[3:0];
        carry               = 4'd0;
      end
    end
    score_add = (carry != 4'd0) ? ALL_NINES : digit_acc;
  end

  // Divider, countdown and score; reload wins over any same-cycle tick or hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      time_left <= TL_LOAD;
      score_q   <= '0;
    end else if (reload) begin
      cnt       <= '0;
      time_left <= TL_LOAD;
      score_q   <= '0;
    end else if (count_en) begin
      cnt <= cnt_at_max ? '0 : cnt + CNT_W'(1);
      if (cnt_at_max) time_left <= time_left - 7'd1;
      if (hit_valid)  score_q   <= score_add;
    end
  end

  // One-cycle flag on the first FINISH cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) finish_pulse <= 1'b0;
    else      finish_pulse <= last_tick;
  end

  // Display row, registered one cycle behind its sources.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ScoreRow <= compose_row(1'b1, TL_LOAD, '0);
    else      ScoreRow <= compose_row(cur_st == ST_IDLE, time_left, score_q);
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: a small instance (TICK_DIV=4, GAME_TICKS=3) for
// flow/score/pause/restart/reset, and a long instance for score saturation.
module tb_game_flow_ctrl;

  localparam int TD = 4, GT = 3, SD = 4, COLS = 8, CW = 5, DARK = 31;
  localparam int TD2 = 16, GT2 = 99;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        en = 1'b0, pause_btn = 1'b0, hit_valid = 1'b0;
  logic [3:0]  hit_points = 4'd0;
  logic [1:0]  state;
  logic        playing, game_tick, finished, finish_pulse;
  logic [6:0]  time_left;
  logic [15:0] score_bcd;
  logic [39:0] score_row;

  logic        en2 = 1'b0, pause2 = 1'b0, hit_valid2 = 1'b0;
  logic [3:0]  hit_points2 = 4'd0;
  logic [1:0]  state2;
  logic        playing2, game_tick2, finished2, finish_pulse2;
  logic [6:0]  time_left2;
  logic [15:0] score_bcd2;
  logic [39:0] score_row2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_q[$];
  int          tick_q[$];
  int          model_score;

  game_flow_ctrl #(.TICK_DIV(TD), .GAME_TICKS(GT), .SCORE_DIGITS(SD),
                   .COLS(COLS), .CELL_W(CW), .DARK_IDX(DARK)) dut (
    .clk(clk), .rst(rst), .en(en), .pause_btn(pause_btn),
    .hit_valid(hit_valid), .hit_points(hit_points),
    .state(state), .playing(playing), .game_tick(game_tick),
    .time_left(time_left), .score_bcd(score_bcd), .ScoreRow(score_row),
    .finished(finished), .finish_pulse(finish_pulse)
  );

  game_flow_ctrl #(.TICK_DIV(TD2), .GAME_TICKS(GT2), .SCORE_DIGITS(SD),
                   .COLS(COLS), .CELL_W(CW), .DARK_IDX(DARK)) dut_sat (
    .clk(clk), .rst(rst), .en(en2), .pause_btn(pause2),
    .hit_valid(hit_valid2), .hit_points(hit_points2),
    .state(state2), .playing(playing2), .game_tick(game_tick2),
    .time_left(time_left2), .score_bcd(score_bcd2), .ScoreRow(score_row2),
    .finished(finished2), .finish_pulse(finish_pulse2)
  );

  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int add_sat(input int cur, input int pts, input int max_v);
    int s;
    s = cur + ((pts > 9) ? 9 : pts);
    return (s > max_v) ? max_v : s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [39:0] idle_row, idle_row2;
    idle_row  = {5'd0, 5'd3, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31};
    idle_row2 = {5'd9, 5'd9, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31};
    rst = 1'b0; en = 1'b1; pause_btn = 1'b1;
    repeat (3) step();
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d, expected 0", state); end
    n_tests++; if (time_left !== 7'd3) begin n_fail++; $display("FAIL reset_time_left: got %0d, expected 3", time_left); end
    n_tests++; if (score_bcd !== 16'h0000) begin n_fail++; $display("FAIL reset_score: got %h, expected 0000", score_bcd); end
    n_tests++; if (finish_pulse !== 1'b0 || finished !== 1'b0) begin n_fail++; $display("FAIL reset_finish: got pulse=%b level=%b, expected 0/0", finish_pulse, finished); end
    n_tests++; if (score_row !== idle_row) begin n_fail++; $display("FAIL reset_row: got %h, expected %h", score_row, idle_row); end
    n_tests++; if (score_row2 !== idle_row2) begin n_fail++; $display("FAIL reset_row_99: got %h, expected %h", score_row2, idle_row2); end
    rst = 1'b1;
    repeat (4) step();
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL held_en_after_reset: got state %0d, expected 0", state); end
    pause_btn = 1'b0;
  endtask

  task automatic test_game_flow();
    int exp_tl;
    en = 1'b0;
    step();
    en = 1'b1;
    step();
    tick_q.delete();
    tick_q.push_back(4); tick_q.push_back(8); tick_q.push_back(12);
    for (int c = 1; c <= 14; c++) begin
      if (c == 1) begin
        n_tests++; if (state !== 2'd1 || playing !== 1'b1) begin n_fail++; $display("FAIL play_entry: got state %0d playing %b, expected 1/1", state, playing); end
        en = 1'b0;
      end
      exp_tl = (c <= 4) ? 3 : (c <= 8) ? 2 : (c <= 12) ? 1 : 0;
      n_tests++; if (time_left !== 7'(exp_tl)) begin n_fail++; $display("FAIL time_left_c%0d: got %0d, expected %0d", c, time_left, exp_tl); end
      if (game_tick === 1'b1) begin
        n_tests++;
        if (tick_q.size() == 0) begin
          n_fail++; $display("FAIL unexpected_tick: got tick at cycle %0d, expected none", c);
        end else begin
          int e;
          e = tick_q.pop_front();
          if (c != e) begin n_fail++; $display("FAIL tick_cycle: got %0d, expected %0d", c, e); end
        end
      end
      if (c == 13) begin
        n_tests++; if (state !== 2'd3 || finished !== 1'b1 || finish_pulse !== 1'b1) begin n_fail++; $display("FAIL finish_entry: got state %0d fin %b pulse %b, expected 3/1/1", state, finished, finish_pulse); end
      end
      if (c == 14) begin
        n_tests++; if (finish_pulse !== 1'b0 || state !== 2'd3) begin n_fail++; $display("FAIL finish_pulse_width: got pulse %b state %0d, expected 0/3", finish_pulse, state); end
      end
      step();
    end
    n_tests++; if (tick_q.size() != 0) begin n_fail++; $display("FAIL missing_ticks: got %0d outstanding, expected 0", tick_q.size()); end
  endtask

  task automatic test_score();
    logic [3:0]  pts[4];
    logic [15:0] e;
    logic [39:0] row_a, row_b;
    pts[0] = 4'd7; pts[1] = 4'd5; pts[2] = 4'd9; pts[3] = 4'd14;
    row_a = {5'd0, 5'd3, 5'd31, 5'd31, 5'd0, 5'd0, 5'd2, 5'd1};
    row_b = {5'd0, 5'd2, 5'd31, 5'd31, 5'd0, 5'd0, 5'd3, 5'd0};
    // restart from FINISH with a coincident hit that must be dropped
    en = 1'b1; hit_valid = 1'b1; hit_points = 4'd8;
    step();
    en = 1'b0; hit_valid = 1'b0;
    n_tests++; if (state !== 2'd1 || time_left !== 7'd3 || score_bcd !== 16'h0000) begin n_fail++; $display("FAIL restart_from_finish: got state %0d tl %0d score %h, expected 1/3/0000", state, time_left, score_bcd); end
    model_score = 0;
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      hit_valid = 1'b1; hit_points = pts[k];
      model_score = add_sat(model_score, int'(pts[k]), 9999);
      exp_q.push_back(to_bcd(model_score));
      step();
      hit_valid = 1'b0;
      e = exp_q.pop_front();
      n_tests++; if (score_bcd !== e) begin n_fail++; $display("FAIL score_hit%0d: got %h, expected %h", k, score_bcd, e); end
    end
    n_tests++; if (score_row !== row_a) begin n_fail++; $display("FAIL row_score21: got %h, expected %h", score_row, row_a); end
    step();
    n_tests++; if (score_row !== row_b) begin n_fail++; $display("FAIL row_score30: got %h, expected %h", score_row, row_b); end
  endtask

  task automatic test_pause();
    logic [15:0] e;
    en = 1'b1;
    step();
    en = 1'b0;
    model_score = 0;
    exp_q.delete();
    step();
    step();
    // cnt is 2 here; pause with a coincident hit that must be dropped
    pause_btn = 1'b1; hit_valid = 1'b1; hit_points = 4'd5;
    exp_q.push_back(to_bcd(model_score));
    step();
    pause_btn = 1'b0;
    n_tests++; if (state !== 2'd2 || playing !== 1'b0) begin n_fail++; $display("FAIL pause_entry: got state %0d playing %b, expected 2/0", state, playing); end
    e = exp_q.pop_front();
    n_tests++; if (score_bcd !== e) begin n_fail++; $display("FAIL pause_rise_hit: got %h, expected %h", score_bcd, e); end
    for (int i = 0; i < 10; i++) begin
      hit_valid = 1'b1; hit_points = 4'd9;
      exp_q.push_back(to_bcd(model_score));
      n_tests++; if (state !== 2'd2 || game_tick !== 1'b0) begin n_fail++; $display("FAIL pause_hold_%0d: got state %0d tick %b, expected 2/0", i, state, game_tick); end
      step();
      e = exp_q.pop_front();
      n_tests++; if (score_bcd !== e) begin n_fail++; $display("FAIL pause_hit_%0d: got %h, expected %h", i, score_bcd, e); end
    end
    hit_valid = 1'b0;
    n_tests++; if (time_left !== 7'd3) begin n_fail++; $display("FAIL pause_time_left: got %0d, expected 3", time_left); end
    pause_btn = 1'b1;
    step();
    pause_btn = 1'b0;
    n_tests++; if (state !== 2'd1 || game_tick !== 1'b0) begin n_fail++; $display("FAIL resume: got state %0d tick %b, expected 1/0", state, game_tick); end
    step();
    n_tests++; if (game_tick !== 1'b1) begin n_fail++; $display("FAIL resume_tick: got %b, expected 1", game_tick); end
    step();
    n_tests++; if (time_left !== 7'd2) begin n_fail++; $display("FAIL resume_time_left: got %0d, expected 2", time_left); end
  endtask

  task automatic test_restart();
    logic [15:0] e;
    int first_tick;
    hit_valid = 1'b1; hit_points = 4'd6;
    model_score = add_sat(model_score, 6, 9999);
    exp_q.push_back(to_bcd(model_score));
    step();
    hit_valid = 1'b0;
    e = exp_q.pop_front();
    n_tests++; if (score_bcd !== e) begin n_fail++; $display("FAIL pre_restart_score: got %h, expected %h", score_bcd, e); end
    en = 1'b1; hit_valid = 1'b1; hit_points = 4'd9;
    step();
    en = 1'b0; hit_valid = 1'b0;
    n_tests++; if (state !== 2'd1 || time_left !== 7'd3 || score_bcd !== 16'h0000) begin n_fail++; $display("FAIL restart_mid_play: got state %0d tl %0d score %h, expected 1/3/0000", state, time_left, score_bcd); end
    first_tick = 0;
    for (int c = 1; c <= 8; c++) begin
      if (game_tick === 1'b1) begin
        first_tick = c;
        break;
      end
      step();
    end
    n_tests++; if (first_tick != 4) begin n_fail++; $display("FAIL restart_cnt: got first tick at cycle %0d, expected 4", first_tick); end
  endtask

  task automatic test_reset_mid();
    int pulses, not_idle;
    step();
    n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL pre_reset_play: got state %0d, expected 1", state); end
    rst = 1'b0;
    #2;
    n_tests++; if (state !== 2'd0 || finished !== 1'b0 || finish_pulse !== 1'b0) begin n_fail++; $display("FAIL async_reset: got state %0d fin %b pulse %b, expected 0/0/0", state, finished, finish_pulse); end
    step();
    rst = 1'b1;
    pulses = 0; not_idle = 0;
    for (int i = 0; i < 20; i++) begin
      if (finish_pulse === 1'b1) pulses++;
      if (state !== 2'd0) not_idle++;
      step();
    end
    n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL post_reset_pulse: got %0d pulses, expected 0", pulses); end
    n_tests++; if (not_idle != 0) begin n_fail++; $display("FAIL post_reset_idle: got %0d non-idle cycles, expected 0", not_idle); end
  endtask

  task automatic test_saturate();
    logic [15:0] e;
    int sb_score, bad;
    en2 = 1'b1;
    step();
    en2 = 1'b0;
    n_tests++; if (state2 !== 2'd1) begin n_fail++; $display("FAIL sat_play: got state %0d, expected 1", state2); end
    sb_score = 0; bad = 0;
    exp_q.delete();
    for (int k = 0; k < 1110; k++) begin
      hit_valid2 = 1'b1; hit_points2 = 4'd9;
      sb_score = add_sat(sb_score, 9, 9999);
      exp_q.push_back(to_bcd(sb_score));
      step();
      e = exp_q.pop_front();
      if (score_bcd2 !== e) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL sat_ramp: got %0d mismatching steps, expected 0", bad); end
    n_tests++; if (score_bcd2 !== 16'h9990) begin n_fail++; $display("FAIL sat_preset: got %h, expected 9990", score_bcd2); end
    hit_points2 = 4'd9;
    step();
    n_tests++; if (score_bcd2 !== 16'h9999) begin n_fail++; $display("FAIL sat_reach: got %h, expected 9999", score_bcd2); end
    hit_points2 = 4'd15;
    step();
    hit_valid2 = 1'b0;
    n_tests++; if (score_bcd2 !== 16'h9999) begin n_fail++; $display("FAIL sat_hold: got %h, expected 9999", score_bcd2); end
    n_tests++; if (state2 !== 2'd1) begin n_fail++; $display("FAIL sat_still_play: got state %0d, expected 1", state2); end
  endtask

  initial begin
    test_reset();
    test_saturate();
    test_game_flow();
    test_score();
    test_pause();
    test_restart();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
